// File: rtl/if_id_pipe.sv
// rtl/if_id_pipe.sv - fetch/decode boundary register with 2-entry skid buffer
// Optional performance counters guarded by IF_ID_PERF_CNT_EN.
module if_id_pipe #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    qpc,
  output logic [INSTR_W-1:0] qinstruction,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic               main_valid, skid_valid;
  logic [PC_W-1:0]    main_pc, skid_pc;
  logic [INSTR_W-1:0] main_instr, skid_instr;

  logic acc, pop;
  logic main_valid_next, skid_valid_next;
  logic main_load, skid_load;

  // in_ready comes straight from a flop, so DECODE stalls never reach FETCH combinationally
  assign in_ready = !skid_valid;
  assign acc      = in_valid & in_ready;
  assign pop      = main_valid & out_ready;

  always_comb begin
    main_valid_next = main_valid;
    skid_valid_next = skid_valid;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (skid_valid) begin
      main_valid_next = 1'b1;
      skid_valid_next = !pop;
    end else begin
      main_valid_next = acc | (main_valid & !pop);
      skid_valid_next = acc & main_valid & !pop;
    end
  end

  // Main refills from skid first, keeping strict FIFO order
  assign main_load = !flush & ((skid_valid & pop) | (acc & (!main_valid | pop)));
  assign skid_load = !flush & acc & main_valid & !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= main_valid_next;
      skid_valid <= skid_valid_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_pc    <= '0;
      main_instr <= NOP_INSTR;
      skid_pc    <= '0;
      skid_instr <= NOP_INSTR;
    end else begin
      if (main_load) begin
        main_pc    <= skid_valid ? skid_pc : pc;
        main_instr <= skid_valid ? skid_instr : instruction;
      end
      if (skid_load) begin
        skid_pc    <= pc;
        skid_instr <= instruction;
      end
    end
  end

  assign out_valid    = main_valid;
  assign qpc          = main_valid ? main_pc : '0;
  assign qinstruction = main_valid ? main_instr : NOP_INSTR;
  assign occupancy    = {1'b0, main_valid} + {1'b0, skid_valid};

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (main_valid && !out_ready && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (flush && main_valid && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/if_id_pipe.md
Name: if_id_pipe

Overview:
- Parametrised successor of the fetch/decode boundary register.
- Carries PC and instruction from FETCH to DECODE with a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready a registered signal, so the stall path does not run combinationally from DECODE back to FETCH.
- Separate flush (squash to bubble) and backpressure (hold) controls replace the single stall-clears-register behaviour.

Parameters:
- PC_W, 16, PC width in bits.
- INSTR_W, 16, instruction width in bits.
- NOP_INSTR, 0, instruction value driven on qinstruction whenever out_valid=0.
- CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all held entries (branch/exception redirect).
- in_valid  in  1  FETCH presents a valid pc/instruction.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- pc  in  PC_W  PC from FETCH.
- instruction  in  INSTR_W  instruction from FETCH.
- out_valid  out  1  qpc/qinstruction valid toward DECODE.
- out_ready  in  1  DECODE accepts (equivalent to !stall).
- qpc  out  PC_W  PC to DECODE.
- qinstruction  out  INSTR_W  instruction to DECODE.
- occupancy  out  2  number of held entries, 0..2.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- flush_cnt  out  CNT_W  flush events that discarded at least one valid entry.

Behaviour:
- State: main entry {main_valid, main_pc, main_instr}; skid entry {skid_valid, skid_pc, skid_instr}.
- Reset (async, rst_n=0):
  - both valids=0; in_ready=1; out_valid=0; qpc=0; qinstruction=NOP_INSTR; occupancy=0; counters=0.
  - Reset asserted mid-transfer discards all data immediately.
- Output mapping:
  - out_valid=main_valid.
  - qpc=main_valid ? main_pc : 0.
  - qinstruction=main_valid ? main_instr : NOP_INSTR.
  - Bubbles are never X.
- Handshake definitions: acc = in_valid & in_ready; pop = out_valid & out_ready.
- States (occupancy):
  - EMPTY(0): acc -> main loaded, FULL1.
  - FULL1(1), main only:
    - pop & acc -> main replaced by input, stay FULL1.
    - pop & !acc -> EMPTY.
    - !pop & acc -> input written to skid, FULL2.
    - !pop & !acc -> hold.
  - FULL2(2), main+skid; in_ready=0, so acc is impossible:
    - pop -> main<=skid, skid_valid<=0, FULL1.
    - !pop -> hold.
- Ordering: strict FIFO. Skid content always reaches main before any newer input.
- Latency: input accepted in cycle N appears on qpc/qinstruction in cycle N+1 when the stage was empty or popping. Throughput is 1 per cycle with no bubbles while out_ready=1.
- in_ready is registered: it deasserts the cycle after the skid fills and reasserts the cycle after the skid drains.
- flush=1 (highest priority except reset):
  - next state EMPTY; any acc in the same cycle is discarded.
  - in_ready=1 the following cycle.
  - pop in the flush cycle still completes (DECODE consumes the current main).
- Data registers load only on their write enable; they hold otherwise, with no toggling on bubbles.
- out_valid must not drop without a pop or flush; data must be stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - flush_cnt increments on each flush cycle with occupancy>0.
  - Both saturate at all-ones and clear on reset.
- Undefined: stall_cnt and flush_cnt are tied to 0; no counter flops are synthesised.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-stream -> out_valid=0, qinstruction=NOP_INSTR, qpc=0, in_ready=1, occupancy=0 without waiting for a clock edge.
- Streaming: out_ready=1, in_valid=1 with pc=0x0000,0x0002,0x0004 on consecutive cycles -> qpc 0x0000,0x0002,0x0004 one cycle later each; occupancy stays 1; no bubbles.
- Backpressure: out_ready=0 with main holding pc=0x0010; push pc=0x0012 -> occupancy=2, in_ready=0 next cycle, qpc held at 0x0010. Release out_ready -> 0x0010 then 0x0012 in order, in_ready=1 one cycle later.
- Flush: occupancy=2 and flush=1 with in_valid=1 pc=0x0020 -> next cycle out_valid=0, qinstruction=NOP_INSTR, occupancy=0, 0x0020 never appears at the output.
- Flush+pop: occupancy=1, out_ready=1, flush=1 -> DECODE observes the pop in that cycle; stage is empty next cycle.
- Perf (IF_ID_PERF_CNT_EN defined): hold out_ready=0 for 5 cycles with out_valid=1, then one flush at occupancy 2 -> stall_cnt=5, flush_cnt=1. With the macro undefined -> both read 0.
